kamus_muldiv_seq: RTL and testbench

KAMUS_MULDIV_SEQ -- requirements
Module: kamus_muldiv_seq

---
 rtl/kamus_muldiv_seq.sv | 200 ++++++++++++++++++++
 tb/tb_kamus_muldiv_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/kamus_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on 32-bit magnitudes, with one completion strobe per accepted request.
module kamus_muldiv_seq #(
    parameter bit BYPASS_SPECIAL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  funct_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        result_valid_o,
    output logic [31:0] result_o,
    output logic [4:0]  rd_addr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_REM    = 3'd6;

    state_e      state_q,  state_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [2:0]  funct_q,  funct_d;
    logic        neg_q,    neg_d;
    logic [63:0] acc_q,    acc_d;
    logic [31:0] opb_q,    opb_d;
    logic [4:0]  rd_q,     rd_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;

    // Operand decode at the accept edge
    logic        signed_a, signed_b, sa, sb;
    logic [31:0] mag_a, mag_b;
    logic        is_div_in, div0_in, ovf_in, special_in;
    logic [31:0] special_res;
    logic        neg_in;

    // Iteration step and final fix-up
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] step;
    logic [63:0] prod_fix;
    logic [31:0] div_val;
    logic [31:0] final_res;

    always_comb begin
        signed_a = (funct_i == F_MUL) || (funct_i == F_MULH) || (funct_i == F_MULHSU) ||
                   (funct_i == F_DIV) || (funct_i == F_REM);
        signed_b = (funct_i == F_MUL) || (funct_i == F_MULH) ||
                   (funct_i == F_DIV) || (funct_i == F_REM);
        sa       = signed_a & rs1_data_i[31];
        sb       = signed_b & rs2_data_i[31];
        mag_a    = sa ? (32'd0 - rs1_data_i) : rs1_data_i;
        mag_b    = sb ? (32'd0 - rs2_data_i) : rs2_data_i;

        is_div_in  = funct_i[2];
        div0_in    = (rs2_data_i == 32'd0);
        ovf_in     = funct_i[2] & ~funct_i[0] &
                     (rs1_data_i == 32'h8000_0000) & (rs2_data_i == 32'hFFFF_FFFF);
        special_in = is_div_in & (div0_in | ovf_in);

        if (div0_in) begin
            special_res = funct_i[1] ? rs1_data_i : 32'hFFFF_FFFF;
        end else begin
            special_res = funct_i[1] ? 32'd0 : 32'h8000_0000;
        end

        // Quotient of a divide-by-zero stays all-ones; remainder follows the dividend.
        if (!is_div_in) begin
            neg_in = sa ^ sb;
        end else if (!funct_i[1]) begin
            neg_in = (sa ^ sb) & ~div0_in;
        end else begin
            neg_in = sa;
        end
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};

        // The shifted partial remainder is below 2*divisor, so a 32-bit difference suffices.
        div_ge   = ({acc_q[63:31]} >= {1'b0, opb_q});
        div_diff = acc_q[62:31] - opb_q;
        div_next = div_ge ? {div_diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};

        step     = funct_q[2] ? div_next : mul_next;

        prod_fix = neg_q ? (64'd0 - step) : step;
        div_val  = funct_q[1] ? step[63:32] : step[31:0];

        if (funct_q[2]) begin
            final_res = neg_q ? (32'd0 - div_val) : div_val;
        end else if (funct_q == F_MUL) begin
            final_res = prod_fix[31:0];
        end else begin
            final_res = prod_fix[63:32];
        end
    end

    // NOTE: every next-state signal takes its held value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct_d  = funct_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        rd_d     = rd_q;
        result_d = result_q;
        rd_out_d = rd_out_q;

        unique case (state_q)
            IDLE: begin
                if (valid_i && !flush_i) begin
                    funct_d = funct_i;
                    neg_d   = neg_in;
                    acc_d   = {32'd0, mag_a};
                    opb_d   = mag_b;
                    rd_d    = rd_addr_i;
                    cnt_d   = 5'd31;
                    if (BYPASS_SPECIAL && special_in) begin
                        state_d  = DONE;
                        result_d = special_res;
                        rd_out_d = rd_addr_i;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step;
                    if (cnt_q == 5'd0) begin
                        state_d  = DONE;
                        result_d = final_res;
                        rd_out_d = rd_q;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            funct_q  <= 3'd0;
            neg_q    <= 1'b0;
            acc_q    <= 64'd0;
            opb_q    <= 32'd0;
            rd_q     <= 5'd0;
            result_q <= 32'd0;
            rd_out_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct_q  <= funct_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign ready_o        = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign result_valid_o = (state_q == DONE);
    assign result_o       = result_q;
    assign rd_addr_o      = rd_out_q;

endmodule

// File: tb/tb_kamus_muldiv_seq.sv
// Directed bench for kamus_muldiv_seq: vector table for results and latency,
// plus hand-written flush, reset and accept-gating sequences.
module tb_kamus_muldiv_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  funct_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        busy_o;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    kamus_muldiv_seq #(.BYPASS_SPECIAL(1'b1)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .funct_i        (funct_i),
        .rs1_data_i     (rs1_data_i),
        .rs2_data_i     (rs2_data_i),
        .rd_addr_i      (rd_addr_i),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .rd_addr_o      (rd_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Caller is at a negedge with the unit idle; the next posedge is E0.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy_n;
        valid_i    = 1'b1;
        funct_i    = f;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_addr_i  = rd;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        lat     = 1;
        busy_n  = 0;
        while (!result_valid_o && lat < 100) begin
            busy_n += int'(busy_o);
            @(negedge clk_i);
            lat++;
        end
        busy_n += int'(busy_o);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy cycles"}, busy_n, exp_lat);
        check({tag, " result"}, result_o, exp);
        check({tag, " rd"}, {27'd0, rd_addr_o}, {27'd0, rd});
        @(negedge clk_i);
        check({tag, " strobe one cycle"}, {31'd0, result_valid_o}, 32'd0);
        check({tag, " ready after"}, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        int strobes;

        vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         33};
        vecs[8]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, 33};
        vecs[9]  = '{3'd3, 32'h8000_0000, 32'd2,         5'd11, 32'h0000_0001, 33};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'd2,         5'd12, 32'hC000_0000, 33};
        vecs[11] = '{3'd7, 32'd7,         32'd100,       5'd13, 32'd7,         33};
        vecs[12] = '{3'd5, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd6, 32'd5,         32'd0,         5'd15, 32'd5,         1};
        vecs[14] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1};
        vecs[15] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1};
        vecs[16] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         5'd18, 32'hFFFF_FFFF, 1};
        vecs[17] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         5'd19, 32'hFFFF_FFF9, 1};

        rst_ni     = 1'b0;
        valid_i    = 1'b0;
        flush_i    = 1'b0;
        funct_i    = 3'd0;
        rs1_data_i = 32'd0;
        rs2_data_i = 32'd0;
        rd_addr_i  = 5'd0;
        #1;
        check("reset ready", {31'd0, ready_o}, 32'd1);
        check("reset busy", {31'd0, busy_o}, 32'd0);
        check("reset strobe", {31'd0, result_valid_o}, 32'd0);
        check("reset result", result_o, 32'd0);
        check("reset rd", {27'd0, rd_addr_o}, 32'd0);

        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // First vector is issued on the very first edge after reset release.
        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].funct, vecs[i].a, vecs[i].b,
                   vecs[i].rd, vecs[i].exp, vecs[i].lat);
        end

        // Flush and valid together in IDLE: not accepted.
        valid_i = 1'b1;
        flush_i = 1'b1;
        funct_i = 3'd0;
        rs1_data_i = 32'd3;
        rs2_data_i = 32'd4;
        rd_addr_i  = 5'd9;
        @(negedge clk_i);
        check("flush+valid idle busy", {31'd0, busy_o}, 32'd0);
        valid_i = 1'b0;
        flush_i = 1'b0;

        // Flush mid-multiply: high during the cycle E0+10..E0+11.
        valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (10) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush ready", {31'd0, ready_o}, 32'd1);
        check("flush busy", {31'd0, busy_o}, 32'd0);
        check("flush strobe", {31'd0, result_valid_o}, 32'd0);
        check("flush result held", result_o, 32'hFFFF_FFF9);
        check("flush rd held", {27'd0, rd_addr_o}, {27'd0, 5'd19});
        run_op("after flush", 3'd0, 32'd3, 32'd4, 5'd9, 32'd12, 33);

        // Reset pulsed at E0+20.
        valid_i    = 1'b1;
        funct_i    = 3'd0;
        rs1_data_i = 32'd6;
        rs2_data_i = 32'd7;
        rd_addr_i  = 5'd20;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (19) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("midreset ready", {31'd0, ready_o}, 32'd1);
        check("midreset busy", {31'd0, busy_o}, 32'd0);
        check("midreset strobe", {31'd0, result_valid_o}, 32'd0);
        check("midreset result", result_o, 32'd0);
        check("midreset rd", {27'd0, rd_addr_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        strobes = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            strobes += int'(result_valid_o);
        end
        check("no strobe after reset", strobes, 32'd0);
        run_op("after reset", 3'd0, 32'd6, 32'd7, 5'd20, 32'd42, 33);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
